// File: rtl/ysyx_23060184_pkg.sv
// Shared types and constants for the ysyx_23060184 AXI read path.
// Holds the read-master state encoding, AXI IDs, response/burst codes and the IFU fetch size.
package ysyx_23060184_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } rd_state_e;

    localparam logic [3:0] IFU_ID     = 4'd0;
    localparam logic [3:0] LSU_ID     = 4'd1;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] IFU_ARSIZE = 3'b010;

    // A single-beat response is bad if the slave flags it, if it is not
    // the last beat, or if it belongs to another ID.
    function automatic logic rsp_bad(
        input logic [1:0] resp,
        input logic       last,
        input logic [3:0] rid,
        input logic [3:0] exp_id
    );
        return (resp != RESP_OKAY) | ~last | (rid != exp_id);
    endfunction

endpackage

// File: rtl/ysyx_23060184_rd_watchdog.sv
// Saturating response watchdog for the AXI read master.
// Ports: i_clr zeroes the count, i_en advances it, o_timeout is high at TIMEOUT.
module ysyx_23060184_rd_watchdog
    import ysyx_23060184_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = (r_cnt == LIMIT);

endmodule

// File: rtl/ysyx_23060184_axi_rd_master.sv
// Single-beat AXI4 read master behind the IFU/LSU arbiter; routes data/error to the owner.
// Ports: grants + address in, io_master AR/R out/in, per-requester pulses, busy, sticky bus_err.
module ysyx_23060184_axi_rd_master
    import ysyx_23060184_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ifu_grant,
    input  logic                  lsu_grant,
    input  logic [DATA_WIDTH-1:0] req_araddr,
    input  logic [2:0]            lsu_arsize,
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [DATA_WIDTH-1:0] io_master_araddr,
    output logic [3:0]            io_master_arid,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_WIDTH-1:0] io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast,
    input  logic [3:0]            io_master_rid,
    output logic                  ifu_rvalid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic                  ifu_rerr,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_rerr,
    output logic                  busy,
    output logic                  bus_err
);

    rd_state_e r_state;
    rd_state_e w_state_nxt;

    logic                  w_grant;
    logic                  w_wd_timeout;
    logic                  w_latch;
    logic                  w_rsp_fire;
    logic                  w_rsp_err;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_arvalid_nxt;
    logic                  w_rready_nxt;
    logic                  w_busy_nxt;
    logic                  w_ifu_rvalid_nxt;
    logic                  w_lsu_rvalid_nxt;
    logic                  w_set_bus_err;

    logic                  r_owner_lsu;
    logic                  r_arvalid;
    logic [DATA_WIDTH-1:0] r_araddr;
    logic [3:0]            r_arid;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic                  r_rready;
    logic                  r_ifu_rvalid;
    logic [DATA_WIDTH-1:0] r_ifu_rdata;
    logic                  r_ifu_rerr;
    logic                  r_lsu_rvalid;
    logic [DATA_WIDTH-1:0] r_lsu_rdata;
    logic                  r_lsu_rerr;
    logic                  r_busy;
    logic                  r_bus_err;

    assign w_grant = ifu_grant | lsu_grant;

    // The count restarts every time R is entered and only runs while
    // the slave has not answered.
    ysyx_23060184_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (r_state != ST_R),
        .i_en      ((r_state == ST_R) & ~io_master_rvalid),
        .o_timeout (w_wd_timeout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                if (io_master_arready) begin
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                // A response in the final watchdog cycle still wins.
                if (io_master_rvalid) begin
                    w_state_nxt = ST_DONE;
                end else if (w_wd_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition.
    always_comb begin
        w_latch          = (r_state == ST_IDLE) & w_grant;
        w_rsp_fire       = (r_state == ST_R) & (w_state_nxt != ST_R);
        w_rsp_err        = 1'b1;
        w_rsp_data       = '0;
        if (io_master_rvalid) begin
            w_rsp_err  = rsp_bad(io_master_rresp, io_master_rlast,
                                 io_master_rid, r_arid);
            w_rsp_data = io_master_rdata;
        end
        w_arvalid_nxt    = (w_state_nxt == ST_AR);
        w_rready_nxt     = (w_state_nxt == ST_R);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_ifu_rvalid_nxt = w_rsp_fire & ~r_owner_lsu;
        w_lsu_rvalid_nxt = w_rsp_fire & r_owner_lsu;
        w_set_bus_err    = (r_state == ST_R) & (w_state_nxt == ST_ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner_lsu  <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arid       <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
            r_rready     <= 1'b0;
            r_ifu_rvalid <= 1'b0;
            r_ifu_rdata  <= '0;
            r_ifu_rerr   <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= '0;
            r_lsu_rerr   <= 1'b0;
            r_busy       <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_owner_lsu <= lsu_grant;
                r_araddr    <= req_araddr;
                r_arid      <= lsu_grant ? LSU_ID : IFU_ID;
                r_arsize    <= lsu_grant ? lsu_arsize : IFU_ARSIZE;
                r_arburst   <= BURST_INCR;
            end
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_busy       <= w_busy_nxt;
            r_ifu_rvalid <= w_ifu_rvalid_nxt;
            r_lsu_rvalid <= w_lsu_rvalid_nxt;
            // Data/error hold between pulses; only the owner's copy moves.
            if (w_ifu_rvalid_nxt) begin
                r_ifu_rdata <= w_rsp_data;
                r_ifu_rerr  <= w_rsp_err;
            end
            if (w_lsu_rvalid_nxt) begin
                r_lsu_rdata <= w_rsp_data;
                r_lsu_rerr  <= w_rsp_err;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign io_master_arvalid = r_arvalid;
    assign io_master_araddr  = r_araddr;
    assign io_master_arid    = r_arid;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = r_arsize;
    assign io_master_arburst = r_arburst;
    assign io_master_rready  = r_rready;
    assign ifu_rvalid        = r_ifu_rvalid;
    assign ifu_rdata         = r_ifu_rdata;
    assign ifu_rerr          = r_ifu_rerr;
    assign lsu_rvalid        = r_lsu_rvalid;
    assign lsu_rdata         = r_lsu_rdata;
    assign lsu_rerr          = r_lsu_rerr;
    assign busy              = r_busy;
    assign bus_err           = r_bus_err;

endmodule

// File: doc/ysyx_23060184_axi_rd_master.md
# ysyx_23060184_axi_rd_master

AXI4 single-beat read master sitting directly downstream of the IFU/LSU read arbiter. Takes the granted request (grant lines plus the arbiter's muxed address), drives the `io_master` AR and R channels, and routes the returned data and error status back to the owning requester. Includes a response watchdog that latches a sticky bus error on a hung slave.

## Interface
- `DATA_WIDTH`, 32: address and data width.
- `TIMEOUT`, 255: maximum cycles in R-wait before the watchdog fires; must be at least 1.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `ifu_grant` in 1: arbiter grant to IFU.
- `lsu_grant` in 1: arbiter grant to LSU.
- `req_araddr` in DATA_WIDTH: arbiter muxed address.
- `lsu_arsize` in 3: LSU access size.
- `io_master_arvalid` out 1: AR valid.
- `io_master_arready` in 1: AR ready.
- `io_master_araddr` out DATA_WIDTH: AR address.
- `io_master_arid` out 4: AR ID.
- `io_master_arlen` out 8: AR burst length.
- `io_master_arsize` out 3: AR size.
- `io_master_arburst` out 2: AR burst type.
- `io_master_rvalid` in 1: R valid.
- `io_master_rready` out 1: R ready.
- `io_master_rdata` in DATA_WIDTH: R data.
- `io_master_rresp` in 2: R response.
- `io_master_rlast` in 1: R last.
- `io_master_rid` in 4: R ID.
- `ifu_rvalid` out 1: one-cycle response pulse to IFU.
- `ifu_rdata` out DATA_WIDTH: response data to IFU.
- `ifu_rerr` out 1: response error to IFU.
- `lsu_rvalid` out 1: one-cycle response pulse to LSU.
- `lsu_rdata` out DATA_WIDTH: response data to LSU.
- `lsu_rerr` out 1: response error to LSU.
- `busy` out 1: high in any state other than IDLE.
- `bus_err` out 1: sticky watchdog error, cleared only by reset.

## Operation
- **States:** IDLE, AR, R, DONE, ERR.
- **IDLE:**
  - On `lsu_grant | ifu_grant`: latch owner, `req_araddr` and size, then go to AR.
  - Owner is LSU if `lsu_grant` is high, else IFU. LSU wins if both are high, which the arbiter never produces.
  - Size is `lsu_arsize` for LSU and 3'b010 for IFU.
- **AR:**
  - `arvalid`=1; `araddr`, `arid`, `arsize` held stable from registers.
  - Fixed fields: `arid` = 0 for IFU, 1 for LSU; `arlen`=0; `arburst`=2'b01.
  - On `arvalid & arready`: go to R. No timeout in AR, because AXI forbids withdrawing `arvalid`.
- **R:**
  - `rready`=1; watchdog counts cycles.
  - On `rvalid`: latch `rdata`, go to DONE.
  - Error flag = (`rresp` != 0) | ~`rlast` | (`rid` != latched `arid`).
  - If the watchdog reaches TIMEOUT with no `rvalid`: set `bus_err`, latch error=1 and data=0, go to ERR.
- **DONE:** owner's `*_rvalid`=1 for exactly one cycle with latched data and error, then go to IDLE.
- **ERR:**
  - Pulse the owner's `*_rvalid` with `*_rerr`=1 on entry cycle only, `rready`=0.
  - Remain in ERR until reset; grants are ignored.
- **Requester contract:** drop the request in the cycle `*_rvalid` is seen. The grant may reassert from the next cycle.
- **Data outputs:** `*_rdata` and `*_rerr` hold their last value between pulses. The non-owner's outputs are unchanged.
- **Reset mid-transaction:** immediate return to IDLE; all outputs 0; the watchdog is cleared.

## Timing
- All outputs are registered. Reset values are 0 for every output; state is IDLE.
- Grant sampled at edge N: `arvalid` goes high in cycle N+1.
- Minimum grant-to-`rvalid` latency is 3 cycles: `arready` in N+1 and `rvalid` in N+2 give `*_rvalid` in N+3.
- Back-to-back: a grant sampled in the DONE cycle is ignored; a new transaction starts from IDLE at the earliest one cycle after DONE.
- Watchdog:
  - Clears on entry to R.
  - Increments each R cycle without `rvalid`.
  - Fires when count == TIMEOUT, i.e. TIMEOUT+1 R cycles with no response.
  - Counter width is clog2(TIMEOUT+1) and saturates.

## Structure
- The shared `ysyx_23060184` package holds:
  - State encoding enum.
  - IFU/LSU ID constants.
  - AXI `RESP_OKAY` and `BURST_INCR` constants.
  - IFU fetch size constant.
- One sub-module: `ysyx_23060184_rd_watchdog`, a parameterised saturating counter with clear/enable inputs and a `timeout` output.

## Test plan
- **IFU read, zero wait:** `ifu_grant`, addr 0x8000_0000; `arready` and `rvalid` immediate, `rdata` 0x1234_5678, OKAY → `ifu_rvalid` at N+3 with 0x1234_5678, `ifu_rerr`=0, `arid`=0, `arsize`=2.
- **LSU read with stalls:** `lsu_arsize`=0, `arready` delayed 4 cycles, `rvalid` delayed 6 → `araddr` stable throughout AR, `arid`=1, `lsu_rvalid` single pulse, IFU outputs untouched.
- **Response errors:** `rresp`=2'b10 → `lsu_rerr`=1. Separately, `rid`=0 on an LSU request → `lsu_rerr`=1. Separately, `rlast`=0 → error flagged.
- **Watchdog:** TIMEOUT=8, no `rvalid` → after 9 R cycles, `ifu_rvalid` with `ifu_rerr`=1, `bus_err`=1 sticky, subsequent grants ignored until `rstn` pulse.
- **Reset mid-R:** assert `rstn`=0 in R → all outputs 0 asynchronously, state IDLE; the next grant completes normally.
